// File: rtl/tt_pkg.sv
// Shared constants for the PDM/PWM level tile.
//   LEVEL_W            width of level, accumulator, counter and shadow
//   *_BIT / *_LSB      bit positions inside the 8-bit io_in / io_out tile pins
package tt_pkg;

   localparam int LEVEL_W = 5;

   localparam int CLK_BIT   = 0;
   localparam int RSTN_BIT  = 1;
   localparam int WE_BIT    = 2;
   localparam int LEVEL_LSB = 3;

   localparam int PDM_BIT      = 0;
   localparam int PWM_BIT      = 1;
   localparam int READBACK_LSB = 2;
   localparam int STROBE_BIT   = 7;

   typedef logic [LEVEL_W-1:0] level_t;

   localparam level_t CNT_LAST = level_t'((1 << LEVEL_W) - 1);

endpackage

// File: rtl/sigma_delta_mod.sv
// First-order sigma-delta (PDM) modulator.
// A LEVEL_W accumulator adds the level every cycle; the carry out of that add
// is the output bit, so the ones-density over 2**LEVEL_W cycles equals level.
// The accumulator keeps its residue across level changes.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears acc and pdm)
//   level  modulation level, sampled every cycle
//   pdm    registered carry bit
module sigma_delta_mod
   import tt_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  level_t level,
   output logic   pdm
);

   level_t             acc;
   logic [LEVEL_W:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, level};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
         pdm <= 1'b0;
      end else begin
         acc <= sum[LEVEL_W-1:0];
         pdm <= sum[LEVEL_W];
      end
   end

endmodule

// File: rtl/tt_user_module_341521390605697619.sv
// TinyTapeout tile: a 5-bit level register feeding a PDM modulator and a
// 32-step PWM with a frame-aligned shadow compare register.
//   io_in[0]    clock
//   io_in[1]    reset_n, synchronous active-low
//   io_in[2]    write_en, loads level from io_in[7:3]
//   io_in[7:3]  level_in
//   io_out[0]   pdm_out
//   io_out[1]   pwm_out
//   io_out[6:2] level register readback
//   io_out[7]   frame strobe, one cycle per 32
// Every output bit is a flop; nothing in io_in reaches io_out combinationally.
module tt_user_module_341521390605697619
   import tt_pkg::*;
(
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic   clk;
   logic   rst_n;
   logic   write_en;
   level_t level_in;

   assign clk      = io_in[CLK_BIT];
   assign rst_n    = io_in[RSTN_BIT];
   assign write_en = io_in[WE_BIT];
   assign level_in = io_in[LEVEL_LSB +: LEVEL_W];

   level_t level;
   level_t shadow;
   level_t cnt;
   logic   pwm;
   logic   strobe;
   logic   pdm;

   // The shadow only reloads at the end of a frame, so a write mid-frame
   // never changes the period in progress. On a write coinciding with
   // cnt==31 the shadow still takes the old level (nonblocking read).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level  <= '0;
         shadow <= '0;
         cnt    <= '0;
         pwm    <= 1'b0;
         strobe <= 1'b0;
      end else begin
         if (write_en) begin
            level <= level_in;
         end
         if (cnt == CNT_LAST) begin
            shadow <= level;
         end
         cnt    <= cnt + level_t'(1);
         pwm    <= (cnt < shadow);
         strobe <= (cnt == CNT_LAST);
      end
   end

   sigma_delta_mod u_sigma_delta (
      .clk   (clk),
      .rst_n (rst_n),
      .level (level),
      .pdm   (pdm)
   );

   always_comb begin
      io_out                                  = '0;
      io_out[PDM_BIT]                         = pdm;
      io_out[PWM_BIT]                         = pwm;
      io_out[READBACK_LSB +: LEVEL_W]         = level;
      io_out[STROBE_BIT]                      = strobe;
   end

endmodule

// File: tb/tb_tt_user_module_341521390605697619.sv
module tb_tt_user_module_341521390605697619;

   logic       clk;
   logic       rst_n;
   logic       we;
   logic [4:0] lvl;
   logic [7:0] io_in;
   logic [7:0] io_out;

   assign io_in = {lvl, we, rst_n, clk};

   tt_user_module_341521390605697619 dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: level, accumulator residue, position in frame, and the
   // duty latched for the current frame.
   int m_level  = 0;
   int m_acc    = 0;
   int m_cnt    = 0;
   int m_shadow = 0;
   logic [7:0] m_exp = 8'h00;

   int pdm_hi = 0;
   int pwm_hi = 0;

   typedef struct {
      bit         rst_n;
      bit         we;
      logic [4:0] lvl;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit w, input int l);
      int sum;
      bit e_pdm, e_pwm, e_stb;
      if (!r) begin
         m_level = 0; m_acc = 0; m_cnt = 0; m_shadow = 0;
         m_exp = 8'h00;
      end else begin
         sum   = m_acc + m_level;
         e_pdm = (sum >= 32);
         m_acc = sum % 32;
         e_pwm = (m_cnt < m_shadow);
         e_stb = (m_cnt == 31);
         if (m_cnt == 31) m_shadow = m_level;
         m_cnt = (m_cnt + 1) % 32;
         if (w) m_level = l;
         m_exp = 8'((int'(e_stb) << 7) | (m_level << 2) | (int'(e_pwm) << 1) | int'(e_pdm));
      end
   endtask

   task automatic cycle(input bit r, input bit w, input int l);
      @(negedge clk);
      rst_n = r;
      we    = w;
      lvl   = l[4:0];
      @(posedge clk);
      model_edge(r, w, l);
      #1;
      chk("io_out_vs_model", int'(io_out), int'(m_exp));
      pdm_hi += int'(io_out[0]);
      pwm_hi += int'(io_out[1]);
   endtask

   task automatic count_to_strobe(input string name);
      int n;
      bit seen;
      seen = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         cycle(1'b1, 1'b0, 0);
         if (io_out[7]) begin
            n = i;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) n = -1;
      chk(name, n, 32);
   endtask

   task automatic align_frame();
      do cycle(1'b1, 1'b0, 0); while (m_cnt != 0);
   endtask

   initial begin
      int last_hi;
      int idx;
      int pwm_pattern;
      int n;

      rst_n = 1'b0;
      we    = 1'b0;
      lvl   = 5'd0;

      // Reset held 3 edges with junk inputs, then release writing level 8 and
      // watch the accumulator reach its first carry.
      tbl[0] = '{1'b0, 1'b1, 5'd5,  8'h00};
      tbl[1] = '{1'b0, 1'b0, 5'd31, 8'h00};
      tbl[2] = '{1'b0, 1'b1, 5'd17, 8'h00};
      tbl[3] = '{1'b1, 1'b1, 5'd8,  8'h20};
      tbl[4] = '{1'b1, 1'b0, 5'd0,  8'h20};
      tbl[5] = '{1'b1, 1'b0, 5'd0,  8'h20};
      tbl[6] = '{1'b1, 1'b0, 5'd0,  8'h20};
      tbl[7] = '{1'b1, 1'b0, 5'd0,  8'h21};
      tbl[8] = '{1'b1, 1'b0, 5'd0,  8'h20};

      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].rst_n, tbl[i].we, int'(tbl[i].lvl));
         chk($sformatf("table[%0d]", i), int'(io_out), int'(tbl[i].exp));
      end

      // First strobe: release edge was table[3]; 6 edges done so far.
      n = 6;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 1'b0, 0);
         n++;
         if (io_out[7]) break;
      end
      chk("first_strobe_edges", n, 32);

      // PDM level 8: one high every 4 cycles, 16 in 64.
      pdm_hi = 0;
      last_hi = -1;
      for (int i = 0; i < 64; i++) begin
         cycle(1'b1, 1'b0, 0);
         if (io_out[0]) begin
            if (last_hi >= 0) chk("pdm8_gap", i - last_hi, 4);
            last_hi = i;
         end
      end
      chk("pdm8_count", pdm_hi, 16);

      // PWM 26 written mid-frame at cnt 3: remainder of frame keeps duty 8.
      while (m_cnt != 3) cycle(1'b1, 1'b0, 0);
      pwm_hi = 0;
      cycle(1'b1, 1'b1, 26);
      while (m_cnt != 0) cycle(1'b1, 1'b0, 0);
      chk("pwm_old_duty_tail", pwm_hi, 5);
      pwm_pattern = 0;
      pwm_hi = 0;
      for (int i = 0; i < 32; i++) begin
         cycle(1'b1, 1'b0, 0);
         if (io_out[1]) pwm_pattern |= (1 << i);
      end
      chk("pwm26_count", pwm_hi, 26);
      chk("pwm26_pattern", pwm_pattern, 32'h03ff_ffff);

      // Extremes.
      cycle(1'b1, 1'b1, 0);
      align_frame();
      pdm_hi = 0; pwm_hi = 0;
      for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 0);
      chk("lvl0_pdm", pdm_hi, 0);
      chk("lvl0_pwm", pwm_hi, 0);

      cycle(1'b1, 1'b1, 31);
      align_frame();
      pdm_hi = 0; pwm_hi = 0;
      for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 0);
      chk("lvl31_pdm", pdm_hi, 62);
      chk("lvl31_pwm", pwm_hi, 62);

      // Level change with write_en held: 15 then 4.
      for (int i = 0; i < 64; i++) begin
         if (i == 32) pdm_hi = 0;
         cycle(1'b1, 1'b1, 15);
      end
      chk("lvl15_pdm_window", pdm_hi, 15);
      for (int i = 0; i < 64; i++) begin
         if (i == 32) pdm_hi = 0;
         cycle(1'b1, 1'b1, 4);
      end
      chk("lvl4_pdm_window", pdm_hi, 4);

      // Mid-frame reset at cnt 17.
      idx = 0;
      while (m_cnt != 17 && idx < 40) begin
         cycle(1'b1, 1'b0, 0);
         idx++;
      end
      cycle(1'b0, 1'b1, 9);
      chk("midreset_out", int'(io_out), 0);
      count_to_strobe("midreset_strobe_edges");
      chk("midreset_level", int'(io_out[6:2]), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
               int'($urandom_range(0, 31)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_user_module_341521390605697619.md
Name: tt_user_module_341521390605697619

Overview:
- TinyTapeout-2 user tile: a 5-bit level register drives two modulators, a first-order PDM (sigma-delta) and a 32-step PWM.
- All I/O goes through the standard 8-bit io_in/io_out tile pins.
- The block sits directly behind the tile wrapper; io_out drives LEDs/pins.

Parameters:
- LEVEL_W, 5, level/accumulator/counter width. Fixed by pin budget; not overridable in the tile.

Ports:
- io_in[0]  input  1  clock; all state updates on its rising edge.
- io_in[1]  input  1  reset_n; synchronous, active-low. 0 at a rising edge resets all state.
- io_in[2]  input  1  write_en; loads the level register when 1.
- io_in[7:3]  input  5  level_in; new modulation level, 0..31.
- io_out[0]  output  1  pdm_out
- io_out[1]  output  1  pwm_out
- io_out[6:2]  output  5  level register readback
- io_out[7]  output  1  frame strobe

Behaviour:
- Clocking: one clock domain; every output is a flop output with no combinational path from io_in to io_out.
- Reset (reset_n=0 at a clock edge), regardless of other inputs:
  - level, shadow, acc and cnt clear to 0.
  - io_out = 8'h00 from the following edge.
  - Reset has priority over write_en.
  - Mid-operation reset aborts the current frame; counting restarts from cnt=0.
- Level register:
  - If write_en=1 at an edge (not in reset), level <= level_in.
  - Readback io_out[6:2] shows the new value one cycle later.
  - Holding write_en=1 reloads every cycle.
- PDM:
  - 5-bit accumulator acc. Each edge: {carry, acc} <= acc + level (6-bit sum); pdm_out <= carry.
  - Uses the current level register, not a shadow copy.
  - Output density is exactly level/32 over any 32 consecutive cycles once level is stable.
  - level=0 gives constant 0. level=31 gives 31 highs per 32 cycles, never constant 1.
  - The accumulator is not cleared on a level change; the residue carries over.
- PWM:
  - Free-running 5-bit counter cnt, incremented every cycle, wrapping 31 -> 0.
  - Compare value is a shadow register: shadow <= level on the edge where cnt==31. The duty cycle therefore changes only on frame boundaries; mid-frame writes do not glitch the current period.
  - pwm_out <= (cnt < shadow), unsigned compare.
  - shadow=0 gives constant 0; shadow=k gives k high cycles per 32, starting at the frame beginning.
- Frame strobe: io_out[7] <= (cnt==31). One-cycle pulse, period 32 cycles, first pulse 32 edges after reset release.
- Simultaneous write_en and cnt==31: shadow takes the old level value. The new level reaches the PWM one frame later.
- Arithmetic is unsigned and modulo 32 throughout; no saturation.
- Estimated RTL: roughly 150 lines.

Decomposition:
- Shared package tt_pkg:
  - LEVEL_W=5
  - pin-index localparams CLK_BIT=0, RSTN_BIT=1, WE_BIT=2, LEVEL_LSB=3
- One natural sub-module, sigma_delta_mod: acc + carry output, with ports clk, rst_n, level, pdm. The PWM, counter and strobe logic stay in the top module.

Test Plan:
- Reset:
  - Hold reset_n=0 for 3 edges with arbitrary write_en/level_in -> io_out==8'h00 throughout.
  - Release reset_n -> first io_out[7] pulse exactly 32 edges later.
- PDM, level 8:
  - Write level 8 (write_en=1 one cycle) -> io_out[6:2]==8 next cycle.
  - pdm_out high exactly once every 4 cycles; 16 highs in 64 cycles.
- PWM, level 26 (5'h1a):
  - Write 5'h1a mid-frame -> current frame keeps the old duty.
  - Next full frame: pwm_out high for cnt 0..25 (26 cycles), low for 6 cycles.
- Extremes:
  - Level 0 -> pdm_out and pwm_out stay 0 for 64 cycles.
  - Level 31 (5'h1f) -> 62 highs on each output over 64 cycles.
- Level change 5'h0f then 5'h04, each held 64 cycles with write_en=1:
  - PDM density tracks 15/32 then 4/32 (±1 count per window).
  - PWM switches at the frame boundary only.
- Mid-frame reset:
  - Pulse reset_n=0 for 1 edge at cnt=17 -> all outputs 0 next cycle.
  - Counter restarts; strobe 32 edges after release; level reads 0.
